// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of the retired-instruction stream with PC/forced trigger and post-trigger window.
// Optional macro TRACE_FILTER_WB_EN: capture only instructions that write back a register.
module cpu_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_valid,
  input  logic [31:0]   cap_pc,
  input  logic [31:0]   cap_instr,
  input  logic [31:0]   cap_alu,
  input  logic          cap_wb,
  input  logic          arm,
  input  logic [31:0]   trig_pc,
  input  logic          force_trig,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [31:0]   rd_alu,
  output logic [1:0]    state,
  output logic          done,
  output logic [AW:0]   count,
  output logic [AW-1:0] trig_idx
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
  } entry_t;

  localparam logic [AW:0] FULL   = DEPTH[AW:0];
  localparam logic [AW:0] POST_N = POST_TRIG[AW:0];

  entry_t        mem [DEPTH];
  entry_t        rd_q;
  state_t        st;
  logic [AW-1:0] wr_ptr, trig_slot, oldest, rd_slot;
  logic [AW:0]   cnt, post_cnt;
  logic          force_pend, done_q;
  logic          filt, accept, hit;
  logic [1:0]    vld_pipe;

`ifdef TRACE_FILTER_WB_EN
  assign filt = cap_wb;
`else
  // cap_wb still appears in the expression so it counts as consumed
  assign filt = cap_wb | 1'b1;
`endif

  assign accept  = cap_valid && filt && (st == ARMED || st == POST);
  assign hit     = (cap_pc == trig_pc) || force_pend;
  assign oldest  = wr_ptr - cnt[AW-1:0];
  assign rd_slot = oldest + rd_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      wr_ptr     <= '0;
      cnt        <= '0;
      post_cnt   <= '0;
      force_pend <= 1'b0;
      trig_slot  <= '0;
      done_q     <= 1'b0;
    end else if (arm) begin
      // arm wins over any same-cycle capture
      st         <= ARMED;
      wr_ptr     <= '0;
      cnt        <= '0;
      post_cnt   <= '0;
      force_pend <= 1'b0;
      trig_slot  <= '0;
      done_q     <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (cnt != FULL) cnt <= cnt + 1'b1;
      end
      unique case (st)
        ARMED: begin
          if (force_trig) force_pend <= 1'b1;
          if (accept && hit) begin
            trig_slot  <= wr_ptr;
            force_pend <= 1'b0;
            if (POST_N == '0) begin
              st     <= DONE;
              done_q <= 1'b1;
            end else begin
              st <= POST;
            end
          end
        end
        POST: begin
          if (accept) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == POST_N) begin
              st     <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset; contents are qualified by count
  always_ff @(posedge clk) begin
    if (accept && !arm) mem[wr_ptr] <= '{pc: cap_pc, instr: cap_instr, alu: cap_alu};
  end

  assign vld_pipe[0] = rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      rd_q        <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      // non-blocking read sees pre-write contents on a same-slot collision
      if (rd_en) rd_q <= ({1'b0, rd_idx} < cnt) ? mem[rd_slot] : '0;
    end
  end

  assign rd_valid = vld_pipe[1];
  assign rd_pc    = rd_q.pc;
  assign rd_instr = rd_q.instr;
  assign rd_alu   = rd_q.alu;
  assign state    = st;
  assign done     = done_q;
  assign count    = cnt;
  assign trig_idx = (st == POST || st == DONE) ? trig_slot - oldest : '0;

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Parametrised on-chip trace capture for the single-cycle RISC-V core. Samples the retired-instruction stream from `cpu_top` (`pc_out`, `instr_out`, `alu_out`, `reg_write_out`) into a circular buffer. Stops a programmable number of entries after a PC-match or forced trigger. Holds the window for readback by a debug port or bench, replacing ad-hoc hierarchical probing of core internals.

## Interface
- `DEPTH`, 16: entries; power of two, ≥4.
- `POST_TRIG`, 4: entries captured after the trigger entry; 0 ≤ POST_TRIG ≤ DEPTH-1.
- `AW`, `$clog2(DEPTH)`: index width (derived, do not override).

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cap_valid`  in  1  sample qualifier; one instruction retires this cycle.
- `cap_pc`  in  32  from `pc_out`.
- `cap_instr`  in  32  from `instr_out`.
- `cap_alu`  in  32  from `alu_out`.
- `cap_wb`  in  1  from `reg_write_out`.
- `arm`  in  1  pulse; clear buffer and enter ARMED.
- `trig_pc`  in  32  PC match value.
- `force_trig`  in  1  pulse; trigger on next captured entry regardless of PC.
- `rd_en`  in  1  read request.
- `rd_idx`  in  AW  read index; 0 is oldest stored entry.
- `rd_valid`  out  1  read data valid, one cycle after `rd_en`.
- `rd_pc` / `rd_instr` / `rd_alu`  out  32 each  read data.
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- `done`  out  1  high in DONE.
- `count`  out  AW+1  stored entries, saturates at DEPTH.
- `trig_idx`  out  AW  index of trigger entry relative to oldest; valid in POST/DONE.

## Operation
- An entry is "accepted" when `cap_valid`=1, state ∈ {ARMED, POST}, and the filter passes (see Configuration).
- Accepted entry is written at `wr_ptr`; `wr_ptr` increments mod DEPTH; `count` increments to DEPTH, then holds. Oldest = `wr_ptr - count` mod DEPTH.
- IDLE: no capture. `arm` → ARMED with `wr_ptr`=0, `count`=0, `post_cnt`=0, `force_pend`=0.
- ARMED: `force_trig` sets `force_pend`. Trigger fires on an accepted entry when `cap_pc == trig_pc` or `force_pend`. That entry is stored, and its physical slot is latched. Then the FSM goes to POST, or to DONE if POST_TRIG=0.
- POST: each accepted entry increments `post_cnt`. The entry making `post_cnt == POST_TRIG` is stored, then the FSM goes to DONE.
- DONE: no capture; buffer frozen. `arm` restarts.
- `arm` in any state restarts as above; it overrides a same-cycle capture, which is dropped.
- `trig_idx` = latched slot − oldest, mod DEPTH. It is recomputed as oldest moves, so it stays correct after wrap.
- Reads: `rd_en` in any state. Physical slot = oldest + `rd_idx`.
  - If `rd_idx >= count`: data outputs are 0.
  - A same-cycle write to the read slot returns the pre-write contents.

## Timing
- Reset values: `state`=IDLE, `done`=0, `count`=0, `trig_idx`=0, `rd_valid`=0, `rd_pc`/`rd_instr`/`rd_alu`=0; storage contents don't-care.
- Capture: entry is visible to reads from the cycle after acceptance. `count` and `state` update on that same edge.
- Read latency: 1 cycle, registered. `rd_valid` is high exactly one cycle per `rd_en`; data holds until the next read.
- Back-to-back `rd_en` gives one result per cycle.
- Reset mid-POST: immediate IDLE; the trigger is lost.

## Configuration
- `TRACE_FILTER_WB_EN` defined: entries are accepted only when `cap_wb`=1. Stores, branches, and untaken writes are skipped; a trigger PC on a non-writeback instruction never matches.
- Undefined: `cap_wb` is ignored; every `cap_valid` cycle is accepted.

## Test plan
- Reset then idle: assert `reset` 2 cycles, pulse `cap_valid` 5 times without `arm` → `count`=0, `state`=0, reads return zeros with `rd_valid` one cycle later.
- Wrap + PC trigger, DEPTH=8, POST_TRIG=2: `arm`, then capture pc=0x00,0x04,…,0x30 every cycle with `trig_pc`=0x20 → DONE after pc=0x28; `count`=8; `rd_idx` 0..7 give pc 0x0C..0x28; `trig_idx`=5; pc=0x2C not stored.
- POST_TRIG=0: trigger at pc=0x08 (third entry) → DONE same edge; `count`=3; `trig_idx`=2.
- Forced trigger: `arm`, then `force_trig` with `cap_valid`=0, then one capture pc=0x40 → trigger entry pc=0x40; `state`=POST.
- Re-arm collision: in POST, assert `arm` with `cap_valid`=1 → `count`=0, `state`=ARMED, no entry stored.
- Filter, with `TRACE_FILTER_WB_EN`: captures alternate `cap_wb`=1/0 for 6 cycles → `count`=3. Without the macro, the same stimulus → `count`=6.
